// File: rtl/button_debounce_counter.sv
// button_debounce_counter: synchronizes a raw push-button, debounces it with a
// stability counter and FSM, and emits a clean level, press/release strobes and
// a 0-9 BCD press counter for the 7-segment path.
// Optional feature macro: BUTTON_LONG_PRESS_EN (adds long_pulse and its counter).
module button_debounce_counter #(
  parameter int unsigned SYNC_STAGES       = 2,
  parameter int unsigned DEBOUNCE_CYCLES   = 1000000,
  parameter int unsigned LONG_PRESS_CYCLES = 100000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       count_clr,
  output logic       btn_level,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic [3:0] press_count
`ifdef BUTTON_LONG_PRESS_EN
  ,
  output logic       long_pulse
`endif
);

  localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES);

  // Reject parameter values the datapath cannot support.
  if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 2 || LONG_PRESS_CYCLES < 2) begin : g_bad_param
    $error("button_debounce_counter: SYNC_STAGES, DEBOUNCE_CYCLES, LONG_PRESS_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   btn_s;
  state_e                 state_q;
  logic [DCW-1:0]         deb_cnt_q;
  logic                   btn_level_q;
  logic                   press_pulse_q;
  logic                   release_pulse_q;
  logic [3:0]             press_count_q;
  logic                   deb_done;
  logic                   press_accept;

  assign btn_s        = sync_q[SYNC_STAGES-1];
  assign deb_done     = (deb_cnt_q == DCW'(DEBOUNCE_CYCLES - 1));
  assign press_accept = (state_q == PRESS_WAIT) && btn_s && deb_done;

  // Input synchronizer chain; only its last stage is used downstream.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
    end
  end

  // Debounce FSM with stability counter and registered level/strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= IDLE;
      deb_cnt_q       <= '0;
      btn_level_q     <= 1'b0;
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
    end else begin
      press_pulse_q   <= 1'b0;
      release_pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_s) begin
            state_q   <= PRESS_WAIT;
            deb_cnt_q <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!btn_s) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
          end else if (deb_done) begin
            state_q       <= PRESSED;
            deb_cnt_q     <= '0;
            btn_level_q   <= 1'b1;
            press_pulse_q <= 1'b1;
          end else begin
            deb_cnt_q <= deb_cnt_q + DCW'(1);
          end
        end
        PRESSED: begin
          if (!btn_s) begin
            state_q   <= RELEASE_WAIT;
            deb_cnt_q <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (btn_s) begin
            state_q   <= PRESSED;
            deb_cnt_q <= '0;
          end else if (deb_done) begin
            state_q         <= IDLE;
            deb_cnt_q       <= '0;
            btn_level_q     <= 1'b0;
            release_pulse_q <= 1'b1;
          end else begin
            deb_cnt_q <= deb_cnt_q + DCW'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          deb_cnt_q <= '0;
        end
      endcase
    end
  end

  // BCD press counter; a coincident clear takes priority over a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      press_count_q <= 4'd0;
    end else if (count_clr) begin
      press_count_q <= 4'd0;
    end else if (press_accept) begin
      press_count_q <= (press_count_q == 4'd9) ? 4'd0 : press_count_q + 4'd1;
    end
  end

  assign btn_level     = btn_level_q;
  assign press_pulse   = press_pulse_q;
  assign release_pulse = release_pulse_q;
  assign press_count   = press_count_q;

`ifdef BUTTON_LONG_PRESS_EN
  localparam int unsigned LCW = $clog2(LONG_PRESS_CYCLES);

  logic [LCW-1:0] long_cnt_q;
  logic           long_fired_q;
  logic           long_pulse_q;

  // Long-press timer: runs in PRESSED, fires once per press, re-armed only in IDLE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      long_cnt_q   <= '0;
      long_fired_q <= 1'b0;
      long_pulse_q <= 1'b0;
    end else begin
      long_pulse_q <= 1'b0;
      if (state_q == PRESSED) begin
        if (!long_fired_q) begin
          if (long_cnt_q == LCW'(LONG_PRESS_CYCLES - 1)) begin
            long_pulse_q <= 1'b1;
            long_fired_q <= 1'b1;
          end else begin
            long_cnt_q <= long_cnt_q + LCW'(1);
          end
        end
      end else begin
        long_cnt_q <= '0;
        if (state_q == IDLE) begin
          long_fired_q <= 1'b0;
        end
      end
    end
  end

  assign long_pulse = long_pulse_q;
`endif

endmodule

// File: tb/tb_button_debounce_counter.sv
// Self-checking bench for button_debounce_counter: directed scenarios with
// literal expectations plus randomized bouncing input against a run-length model.
module tb_button_debounce_counter;

  localparam int S  = 2;
  localparam int D  = 4;
  localparam int LP = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       btn;
  logic       count_clr;
  logic       btn_level;
  logic       press_pulse;
  logic       release_pulse;
  logic [3:0] press_count;
`ifdef BUTTON_LONG_PRESS_EN
  logic       long_pulse;
`endif

  button_debounce_counter #(
    .SYNC_STAGES      (S),
    .DEBOUNCE_CYCLES  (D),
    .LONG_PRESS_CYCLES(LP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn          (btn),
    .count_clr    (count_clr),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .press_count  (press_count)
`ifdef BUTTON_LONG_PRESS_EN
    ,
    .long_pulse   (long_pulse)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: btn seen through an S-sample delay line; the debounced
  // level flips once D+1 consecutive delayed samples disagree with it.
  bit q_dly[$];
  int m_valid = 0;
  int m_level, m_run, m_cnt;
  int e_press, e_rel;
`ifdef BUTTON_LONG_PRESS_EN
  int m_fired, m_lrun, e_long;
`endif

  always @(posedge clk) begin
    int bs;
    int settled;
    if (!rst_n) begin
      q_dly.delete();
      for (int i = 0; i < S; i++) q_dly.push_back(1'b0);
      m_valid = 1;
      m_level = 0; m_run = 0; m_cnt = 0;
      e_press = 0; e_rel = 0;
`ifdef BUTTON_LONG_PRESS_EN
      m_fired = 0; m_lrun = 0; e_long = 0;
`endif
    end else begin
      bs = int'(q_dly.pop_front());
      q_dly.push_back(btn);
      settled = (m_level == 1 && m_run == 0) ? 1 : 0;
      e_press = 0; e_rel = 0;
      if (bs != m_level) begin
        if (m_run == D) begin
          m_level = 1 - m_level;
          m_run   = 0;
          if (m_level == 1) e_press = 1;
          else              e_rel   = 1;
        end else begin
          m_run++;
        end
      end else begin
        m_run = 0;
      end
      if (count_clr)    m_cnt = 0;
      else if (e_press) m_cnt = (m_cnt + 1) % 10;
`ifdef BUTTON_LONG_PRESS_EN
      e_long = 0;
      if (settled == 1) begin
        if (m_fired == 0) begin
          if (m_lrun == LP - 1) begin
            e_long  = 1;
            m_fired = 1;
          end else begin
            m_lrun++;
          end
        end
      end else begin
        m_lrun = 0;
      end
      if (e_rel == 1) m_fired = 0;
`endif
    end
  end

  int n_press = 0, n_rel = 0, n_long = 0;
  int watch_level = 0, level_dropped = 0;

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge clk) begin
    if (m_valid == 1) begin
      chk("level",   int'(btn_level),     m_level);
      chk("press",   int'(press_pulse),   e_press);
      chk("release", int'(release_pulse), e_rel);
      chk("count",   int'(press_count),   m_cnt);
      chk("excl",    int'(press_pulse & release_pulse), 0);
`ifdef BUTTON_LONG_PRESS_EN
      chk("long",    int'(long_pulse),    e_long);
      if (long_pulse) n_long++;
`endif
      if (press_pulse)   n_press++;
      if (release_pulse) n_rel++;
      if (watch_level == 1 && !btn_level) level_dropped = 1;
    end
  end

  // Waits up to 40 cycles for a strobe; k is the cycle count, -1 on timeout.
  task automatic wait_ev(input int which, output int k);
    logic hit;
    k = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      hit = 1'b0;
      if (which == 0) hit = press_pulse;
      if (which == 1) hit = release_pulse;
`ifdef BUTTON_LONG_PRESS_EN
      if (which == 2) hit = long_pulse;
`endif
      if (hit) begin
        k = i;
        break;
      end
    end
  endtask

  task automatic clean_press(input string tag);
    int k;
    btn = 1'b1;
    wait_ev(0, k);
    chk({tag, "_press_lat"}, k, 7);
    btn = 1'b0;
    wait_ev(1, k);
    chk({tag, "_rel_lat"}, k, 7);
  endtask

  initial begin
    int k, np0, nr0, c0, run, cyc;
    rst_n = 1'b0; btn = 1'b1; count_clr = 1'b0;

    // Reset with button held high
    repeat (3) @(negedge clk);
    chk("rst_level", int'(btn_level), 0);
    chk("rst_press", int'(press_pulse), 0);
    chk("rst_count", int'(press_count), 0);
    rst_n = 1'b1;
    wait_ev(0, k);
    chk("rst_release_lat", k, 7);
    chk("rst_first_count", int'(press_count), 1);
    btn = 1'b0;
    wait_ev(1, k);
    chk("rst_rel_lat", k, 7);

    // Clean press held 20 cycles
    btn = 1'b1;
    wait_ev(0, k);
    chk("clean_press_lat", k, 7);
    chk("clean_level_hi", int'(btn_level), 1);
    @(negedge clk);
    chk("clean_press_1cyc", int'(press_pulse), 0);
    repeat (12) @(negedge clk);
    btn = 1'b0;
    wait_ev(1, k);
    chk("clean_rel_lat", k, 7);
    chk("clean_level_lo", int'(btn_level), 0);
    @(negedge clk);
    chk("clean_rel_1cyc", int'(release_pulse), 0);

    // Bounce on press: 2 high / 2 low, five times
    repeat (3) @(negedge clk);
    np0 = n_press; nr0 = n_rel; c0 = int'(press_count);
    for (int i = 0; i < 5; i++) begin
      btn = 1'b1; repeat (2) @(negedge clk);
      btn = 1'b0; repeat (2) @(negedge clk);
    end
    repeat (10) @(negedge clk);
    chk("bounce_strobes", (n_press - np0) + (n_rel - nr0), 0);
    chk("bounce_level", int'(btn_level), 0);
    chk("bounce_count", int'(press_count), c0);

    // Bounce on release must not drop the level
    btn = 1'b1;
    wait_ev(0, k);
    chk("rb_press_lat", k, 7);
    repeat (3) @(negedge clk);
    nr0 = n_rel; level_dropped = 0; watch_level = 1;
    for (int i = 0; i < 5; i++) begin
      btn = 1'b0; repeat (2) @(negedge clk);
      btn = 1'b1; repeat (2) @(negedge clk);
    end
    repeat (6) @(negedge clk);
    watch_level = 0;
    chk("rb_level_held", level_dropped, 0);
    chk("rb_no_release", n_rel - nr0, 0);
    btn = 1'b0;
    wait_ev(1, k);
    chk("rb_rel_lat", k, 7);

    // Wrap: ten presses from zero
    count_clr = 1'b1; @(negedge clk); count_clr = 1'b0;
    chk("clr_to_zero", int'(press_count), 0);
    for (int i = 0; i < 10; i++) begin
      btn = 1'b1;
      wait_ev(0, k);
      chk("wrap_count", int'(press_count), (i + 1) % 10);
      btn = 1'b0;
      wait_ev(1, k);
    end
    chk("model_wrap", m_cnt, 0);

    // Clear coincident with the third press's acceptance
    clean_press("c1");
    clean_press("c2");
    chk("pre_clr_count", int'(press_count), 2);
    btn = 1'b1;
    repeat (6) @(negedge clk);
    count_clr = 1'b1;
    @(negedge clk);
    count_clr = 1'b0;
    chk("clr_press_pulse", int'(press_pulse), 1);
    chk("clr_wins", int'(press_count), 0);
    btn = 1'b0;
    wait_ev(1, k);

    // Reset in the middle of the press debounce window
    np0 = n_press;
    btn = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_no_press", n_press - np0, 0);
    chk("midrst_level", int'(btn_level), 0);
    rst_n = 1'b1;
    wait_ev(0, k);
    chk("midrst_press_lat", k, 7);
    chk("midrst_count", int'(press_count), 1);
    btn = 1'b0;
    wait_ev(1, k);

`ifdef BUTTON_LONG_PRESS_EN
    // Long press: 40-cycle hold fires once, 16 cycles after the press strobe
    np0 = n_long;
    btn = 1'b1;
    wait_ev(0, k);
    wait_ev(2, k);
    chk("long_lat", k, 16);
    repeat (20) @(negedge clk);
    btn = 1'b0;
    wait_ev(1, k);
    chk("long_once", n_long - np0, 1);
    np0 = n_long;
    btn = 1'b1;
    repeat (10) @(negedge clk);
    btn = 1'b0;
    repeat (15) @(negedge clk);
    chk("short_no_long", n_long - np0, 0);
`endif

    // Randomized bouncing input with occasional clears and resets
    cyc = 0;
    while (cyc < 4000) begin
      btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) run = int'($urandom_range(20, 40));
      else                           run = int'($urandom_range(1, 12));
      for (int j = 0; j < run; j++) begin
        count_clr = ($urandom_range(0, 15) == 0);
        rst_n     = ($urandom_range(0, 299) != 0);
        @(negedge clk);
        cyc++;
      end
    end
    rst_n = 1'b1; count_clr = 1'b0; btn = 1'b0;
    repeat (12) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_debounce_counter.md
Name: button_debounce_counter

Overview:
Input-side counterpart to the on-board LED/7-segment output path. Reads a raw, bouncing push-button or slide-switch and synchronizes it to clk. It then debounces the signal with a stability counter and FSM, and emits a clean level plus single-cycle press/release strobes. It also keeps a 0-9 BCD press counter that can feed the 7-segment decoder directly.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the input synchronizer (>=2)
DEBOUNCE_CYCLES, 1000000, clk cycles the synchronized input must stay stable before acceptance (10 ms at 100 MHz; >=2)
LONG_PRESS_CYCLES, 100000000, cycles held in PRESSED before long_pulse (1 s at 100 MHz); used only with BUTTON_LONG_PRESS_EN

Ports:
clk  input  1  100 MHz on-board clock
rst_n  input  1  synchronous reset, active-low
btn  input  1  raw asynchronous button/switch, active-high
count_clr  input  1  synchronous clear of press_count
btn_level  output  1  debounced level of btn (registered)
press_pulse  output  1  one-cycle strobe on accepted press
release_pulse  output  1  one-cycle strobe on accepted release
press_count  output  4  BCD count of accepted presses, 0..9
long_pulse  output  1  one-cycle long-press strobe (present only with BUTTON_LONG_PRESS_EN)

Behaviour:
- Reset (rst_n=0 at posedge clk): synchronizer chain=0, FSM=IDLE, stability counter=0. Outputs btn_level=0, press_pulse=0, release_pulse=0, press_count=0, long_pulse=0. Reset mid-debounce aborts the window with no strobe.
- Synchronizer: btn passes through SYNC_STAGES flops giving btn_s. Only btn_s is used downstream.
- Stability counter: width $clog2(DEBOUNCE_CYCLES). Cleared on every FSM state entry.
- IDLE: btn_s=1 -> PRESS_WAIT.
- PRESS_WAIT:
  - btn_s=0 -> IDLE; glitch rejected, no strobe.
  - Otherwise the counter increments.
  - At counter==DEBOUNCE_CYCLES-1 with btn_s=1 -> PRESSED. Set btn_level=1, press_pulse=1 for one cycle, press_count advances.
- PRESSED: btn_s=0 -> RELEASE_WAIT.
- RELEASE_WAIT:
  - btn_s=1 -> PRESSED; bounce rejected, no strobe, btn_level stays 1.
  - Otherwise the counter increments.
  - At counter==DEBOUNCE_CYCLES-1 with btn_s=0 -> IDLE. Set btn_level=0, release_pulse=1 for one cycle.
- Latency: btn edge held stable -> btn_level/strobe change = SYNC_STAGES+DEBOUNCE_CYCLES+1 clk cycles.
  - Example: SYNC_STAGES=2, DEBOUNCE_CYCLES=4 gives 7 cycles.
- Strobes: press_pulse and release_pulse are registered and never both high. Each is high exactly one cycle per accepted edge.
- press_count:
  - Counts 0..9, then wraps 9->0 on the next press.
  - count_clr=1 sets it to 0 on the next edge.
  - count_clr coincident with an accepted press: clear wins (count=0), press_pulse is still emitted.
- Input held constant forever: no further strobes. Bounces shorter than DEBOUNCE_CYCLES never change btn_level.

Optional Feature:
BUTTON_LONG_PRESS_EN
- Defined:
  - A second counter (width $clog2(LONG_PRESS_CYCLES)) runs while in PRESSED and clears on leaving PRESSED.
  - When it reaches LONG_PRESS_CYCLES-1, long_pulse=1 for one cycle.
  - Fires at most once per press; the counter saturates until release.
  - Bounce back into PRESSED from RELEASE_WAIT does not restart a fired long press.
- Undefined: long_pulse port and long counter are absent. All other behaviour is identical.

Test Plan:
Bench uses SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_PRESS_CYCLES=16.
- Reset: hold rst_n=0 for 3 cycles with btn=1 -> all outputs 0 while in reset. After release, press_pulse occurs 7 cycles later, press_count=1.
- Clean press/release: btn 0->1, held 20 cycles, then 1->0. Required:
  - press_pulse exactly 1 cycle, 7 cycles after the rise; btn_level=1.
  - release_pulse 1 cycle, 7 cycles after the fall; btn_level=0.
- Bounce rejection:
  - btn toggles high 2 cycles / low 2 cycles, 5 times, then stays low -> no strobes, btn_level=0, press_count unchanged.
  - The same bounce on release never drops btn_level early.
- Wrap and clear:
  - 10 clean presses -> press_count 1,2,...,9,0.
  - count_clr pulsed in the same cycle as the 3rd press's acceptance -> press_count=0, press_pulse still seen.
- Mid-operation reset: assert rst_n=0 at cycle 3 of PRESS_WAIT -> no press_pulse. FSM restarts; btn still high -> press accepted 7 cycles after reset release.
- BUTTON_LONG_PRESS_EN: hold btn high 40 cycles -> exactly one long_pulse, 16 cycles after press_pulse. A press of 10 cycles -> no long_pulse.
